// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite motion sequencer: default screen and
// sprite geometry, the sequencer state type and the direction type.
// -----------------------------------------------------------------------------
package sprite_pkg;

   localparam int unsigned SCREEN_W = 1280;
   localparam int unsigned SCREEN_H = 720;
   localparam int unsigned SPRITE_W = 512;
   localparam int unsigned SPRITE_H = 64;

   // Explicit encodings keep the state register layout identical to the
   // legacy localparam constants.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC_X = 2'd1,
      CALC_Y = 2'd2,
      COMMIT = 2'd3
   } state_t;

   typedef enum logic {
      DIR_NEG = 1'b0,
      DIR_POS = 1'b1
   } dir_t;

endpackage

// File: rtl/sprite_motion_ctrl_axis.sv
// -----------------------------------------------------------------------------
// sprite_axis_step
// Combinational single-axis motion step with edge bounce.
// Ports:
//   i_pos       current position
//   i_dir       current direction (DIR_POS = increasing)
//   i_speed     step in pixels
//   i_max       largest legal position on this axis
//   o_next_pos  position after the step (clamped to 0 / i_max)
//   o_next_dir  direction after the step (flipped on bounce)
//   o_bounced   the step hit an edge and reversed
// -----------------------------------------------------------------------------
module sprite_axis_step
   import sprite_pkg::*;
(
   input  logic [15:0] i_pos,
   input  dir_t        i_dir,
   input  logic [3:0]  i_speed,
   input  logic [15:0] i_max,
   output logic [15:0] o_next_pos,
   output dir_t        o_next_dir,
   output logic        o_bounced
);

   // 17-bit sum so an overshoot past i_max can never wrap.
   logic [16:0] w_sum;
   assign w_sum = {1'b0, i_pos} + {13'd0, i_speed};

   always_comb begin
      o_next_pos = i_pos;
      o_next_dir = i_dir;
      o_bounced  = 1'b0;
      if (i_dir == DIR_POS) begin
         // Landing exactly on i_max is a plain move; only overshoot bounces.
         // A start position already beyond i_max also takes this path.
         if (w_sum > {1'b0, i_max}) begin
            o_next_pos = i_max;
            o_next_dir = DIR_NEG;
            o_bounced  = 1'b1;
         end else begin
            o_next_pos = w_sum[15:0];
         end
      end else begin
         if (i_pos < {12'd0, i_speed}) begin
            o_next_pos = '0;
            o_next_dir = DIR_POS;
            o_bounced  = 1'b1;
         end else begin
            o_next_pos = i_pos - {12'd0, i_speed};
         end
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
// Per-frame motion sequencer. On each rising edge of i_v_sync (while enabled)
// the sprite position is stepped once, X then Y through one shared axis
// stepper, and committed atomically three clocks after the edge is sampled.
// Optional build macro: SPRITE_HIT_COUNT_EN enables the hit-frame counter;
// without it o_hit_frames is held at zero.
// Ports:
//   i_clk, i_rst_n       pixel clock, asynchronous active-low reset
//   i_v_sync             vertical sync (synchronous to i_clk)
//   i_enable             motion enable, sampled in IDLE
//   i_speed_x/_y         per-frame step, sampled in CALC_X / CALC_Y
//   i_sprite_hit         per-pixel opaque hit from the compositor
//   o_sprite_x/_y        committed sprite position
//   o_dir_x/_y           committed direction (1 = increasing)
//   o_bounce             one-clock pulse after a commit that bounced
//   o_hit_frames         saturating count of frames containing a hit
// -----------------------------------------------------------------------------
module sprite_motion_ctrl
   import sprite_pkg::*;
#(
   parameter int unsigned SCREEN_W = sprite_pkg::SCREEN_W,
   parameter int unsigned SCREEN_H = sprite_pkg::SCREEN_H,
   parameter int unsigned SPRITE_W = sprite_pkg::SPRITE_W,
   parameter int unsigned SPRITE_H = sprite_pkg::SPRITE_H,
   parameter int unsigned INIT_X   = 128,
   parameter int unsigned INIT_Y   = 20
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_v_sync,
   input  logic        i_enable,
   input  logic [3:0]  i_speed_x,
   input  logic [3:0]  i_speed_y,
   input  logic        i_sprite_hit,
   output logic [15:0] o_sprite_x,
   output logic [15:0] o_sprite_y,
   output logic        o_dir_x,
   output logic        o_dir_y,
   output logic        o_bounce,
   output logic [7:0]  o_hit_frames
);

   localparam logic [15:0] MAX_X = 16'(SCREEN_W - SPRITE_W);
   localparam logic [15:0] MAX_Y = 16'(SCREEN_H - SPRITE_H);

   state_t      r_state;
   logic        r_v_sync_q;
   logic [15:0] r_x, r_y, r_nx, r_ny;
   dir_t        r_dir_x, r_dir_y, r_ndx, r_ndy;
   logic        r_bx, r_by, r_bounce;

   logic        w_rise;
   logic [15:0] w_pos, w_max, w_next_pos;
   logic [3:0]  w_speed;
   dir_t        w_dir, w_next_dir;
   logic        w_bounced;

   assign w_rise = i_v_sync & ~r_v_sync_q;

   // Shared stepper serves X in CALC_X and Y in CALC_Y.
   assign w_pos   = (r_state == CALC_Y) ? r_y       : r_x;
   assign w_dir   = (r_state == CALC_Y) ? r_dir_y   : r_dir_x;
   assign w_speed = (r_state == CALC_Y) ? i_speed_y : i_speed_x;
   assign w_max   = (r_state == CALC_Y) ? MAX_Y     : MAX_X;

   sprite_axis_step u_axis (
      .i_pos      (w_pos),
      .i_dir      (w_dir),
      .i_speed    (w_speed),
      .i_max      (w_max),
      .o_next_pos (w_next_pos),
      .o_next_dir (w_next_dir),
      .o_bounced  (w_bounced)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_v_sync_q <= 1'b0;
         r_x        <= 16'(INIT_X);
         r_y        <= 16'(INIT_Y);
         r_dir_x    <= DIR_POS;
         r_dir_y    <= DIR_POS;
         r_nx       <= '0;
         r_ny       <= '0;
         r_ndx      <= DIR_POS;
         r_ndy      <= DIR_POS;
         r_bx       <= 1'b0;
         r_by       <= 1'b0;
         r_bounce   <= 1'b0;
      end else begin
         r_v_sync_q <= i_v_sync;
         r_bounce   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rise && i_enable) r_state <= CALC_X;
            end
            CALC_X: begin
               r_nx    <= w_next_pos;
               r_ndx   <= w_next_dir;
               r_bx    <= w_bounced;
               r_state <= CALC_Y;
            end
            CALC_Y: begin
               r_ny    <= w_next_pos;
               r_ndy   <= w_next_dir;
               r_by    <= w_bounced;
               r_state <= COMMIT;
            end
            COMMIT: begin
               r_x      <= r_nx;
               r_y      <= r_ny;
               r_dir_x  <= r_ndx;
               r_dir_y  <= r_ndy;
               r_bounce <= r_bx | r_by;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_sprite_x = r_x;
   assign o_sprite_y = r_y;
   assign o_dir_x    = r_dir_x;
   assign o_dir_y    = r_dir_y;
   assign o_bounce   = r_bounce;

`ifdef SPRITE_HIT_COUNT_EN
   logic       r_hit_seen;
   logic [7:0] r_hit_frames;
   logic       w_frame_end;

   // A frame closes at COMMIT, or at a sync rise that motion ignores because
   // i_enable is low, so counting does not depend on motion being enabled.
   assign w_frame_end = (r_state == COMMIT) ||
                        ((r_state == IDLE) && w_rise && !i_enable);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hit_seen   <= 1'b0;
         r_hit_frames <= '0;
      end else if (w_frame_end) begin
         if (r_hit_seen && (r_hit_frames != 8'hFF))
            r_hit_frames <= r_hit_frames + 8'd1;
         r_hit_seen <= i_sprite_hit;
      end else begin
         r_hit_seen <= r_hit_seen | i_sprite_hit;
      end
   end

   assign o_hit_frames = r_hit_frames;
`else
   logic w_unused_hit;
   assign w_unused_hit = i_sprite_hit;
   assign o_hit_frames = '0;
`endif

endmodule
